// File: rtl/lbp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lbp_pkg : shared FSM states, image geometry and address packing    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package lbp_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SERVE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int IMG_W = 128;
   localparam int IMG_H = 128;
   localparam int DEPTH = IMG_W * IMG_H;

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   // Raster address as the engine forms it: row in the upper bits, column below.
   function automatic logic [ROW_W+COL_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                        input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lbp_host_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lbp_host_ram : DEPTH x DATA_W array, sync write, async read        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module lbp_host_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int c_depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [c_depth];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/lbp_host.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lbp_host : gray-image server and LBP result collector/streamer     |
// | Optional macro LBP_HOST_WRCNT_EN adds wr_count / wr_dup outputs    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module lbp_host
   import lbp_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_in_valid,
   input  logic [DATA_W-1:0] pix_in_data,
   output logic              pix_in_ready,
   output logic              gray_ready,
   input  logic [ADDR_W-1:0] gray_addr,
   input  logic              gray_req,
   output logic [DATA_W-1:0] gray_data,
   input  logic [ADDR_W-1:0] lbp_addr,
   input  logic              lbp_valid,
   input  logic [DATA_W-1:0] lbp_data,
   input  logic              finish,
   output logic              res_out_valid,
   output logic [ADDR_W-1:0] res_out_addr,
   output logic [DATA_W-1:0] res_out_data,
   input  logic              res_out_ready,
   output logic              done
`ifdef LBP_HOST_WRCNT_EN
   ,
   output logic [ADDR_W:0]   wr_count,
   output logic              wr_dup
`endif
);

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic              w_load_hs, w_drain_hs, w_serve_wr;
   logic [DATA_W-1:0] w_gray_rdata;
   logic              w_res_we;
   logic [ADDR_W-1:0] w_res_waddr;
   logic [DATA_W-1:0] w_res_wdata;

   assign w_load_hs  = (r_state == LOAD)  && pix_in_valid;
   assign w_drain_hs = (r_state == DRAIN) && res_out_ready;
   assign w_serve_wr = (r_state == SERVE) && lbp_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= LOAD;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_hs)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_drain_hs) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      pix_in_ready  = 1'b0;
      gray_ready    = 1'b0;
      res_out_valid = 1'b0;
      done          = 1'b0;
      case (r_state)
         LOAD: begin
            pix_in_ready = 1'b1;
            if (pix_in_valid && (r_wr_ptr == '1)) w_state_nxt = SERVE;
         end
         SERVE: begin
            gray_ready = 1'b1;
            if (finish) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            res_out_valid = 1'b1;
            if (res_out_ready && (r_rd_ptr == '1)) w_state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
         end
         default: w_state_nxt = LOAD;
      endcase
   end

   // Loading also clears the result image so stale results never drain.
   assign w_res_we    = w_load_hs || w_serve_wr;
   assign w_res_waddr = w_load_hs ? r_wr_ptr : lbp_addr;
   assign w_res_wdata = w_load_hs ? '0 : lbp_data;

   lbp_host_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_gray_ram (
      .clk   (clk),
      .we    (w_load_hs),
      .waddr (r_wr_ptr),
      .wdata (pix_in_data),
      .raddr (gray_addr),
      .rdata (w_gray_rdata)
   );

   lbp_host_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_res_ram (
      .clk   (clk),
      .we    (w_res_we),
      .waddr (w_res_waddr),
      .wdata (w_res_wdata),
      .raddr (r_rd_ptr),
      .rdata (res_out_data)
   );

   assign gray_data    = ((r_state == SERVE) && gray_req) ? w_gray_rdata : '0;
   assign res_out_addr = r_rd_ptr;

`ifdef LBP_HOST_WRCNT_EN
   logic [ADDR_W:0]   r_wr_count;
   logic [ADDR_W-1:0] r_prev_addr;
   logic              r_prev_vld;
   logic              r_wr_dup;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_count  <= '0;
         r_prev_addr <= '0;
         r_prev_vld  <= 1'b0;
         r_wr_dup    <= 1'b0;
      end else if (w_load_hs && (r_wr_ptr == '1)) begin
         r_wr_count <= '0;
         r_prev_vld <= 1'b0;
      end else if (w_serve_wr) begin
         if (r_wr_count != '1) r_wr_count <= r_wr_count + 1'b1;
         r_prev_addr <= lbp_addr;
         r_prev_vld  <= 1'b1;
         if (r_prev_vld && (lbp_addr == r_prev_addr)) r_wr_dup <= 1'b1;
      end
   end

   assign wr_count = r_wr_count;
   assign wr_dup   = r_wr_dup;
`endif

endmodule
`default_nettype wire
